// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename state (busy bit + ROB tag).
// Optional same-cycle commit-to-read forwarding when REGFILE_BYPASS_EN is defined.
module rename_regfile #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int TAG_W    = 4,
    parameter int NUM_RD   = 2,
    localparam int REG_W   = $clog2(NUM_REGS),
    localparam int CNT_W   = REG_W + 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush_in,
    input  logic                      iss_en,
    input  logic [REG_W-1:0]          iss_rd,
    input  logic [TAG_W-1:0]          iss_tag,
    input  logic                      cmt_en,
    input  logic [REG_W-1:0]          cmt_rd,
    input  logic [XLEN-1:0]           cmt_val,
    input  logic [TAG_W-1:0]          cmt_tag,
    input  logic [NUM_RD*REG_W-1:0]   rd_addr,
    output logic [NUM_RD*XLEN-1:0]    rd_val,
    output logic [NUM_RD-1:0]         rd_busy,
    output logic [NUM_RD*TAG_W-1:0]   rd_tag,
    output logic [CNT_W-1:0]          busy_cnt
);

    logic [XLEN-1:0]     val_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [CNT_W-1:0]    cnt_q;

    // rdy_in is a whole-block stall, not a handshake: when low, every edge is a
    // no-op and issue/commit/flush are dropped rather than held.
    logic iss_ok;
    logic cmt_ok;
    logic cmt_clr;
    logic flush_ok;
    logic cnt_inc;
    logic cnt_dec;

    assign flush_ok = rdy_in && flush_in;
    assign iss_ok   = rdy_in && iss_en && !flush_in && (iss_rd != '0);
    assign cmt_ok   = rdy_in && cmt_en && (cmt_rd != '0);
    assign cmt_clr  = cmt_ok && busy_q[cmt_rd] && (tag_q[cmt_rd] == cmt_tag);

    // A clear on the register being re-renamed in the same cycle is overridden.
    assign cnt_inc  = iss_ok && !busy_q[iss_rd];
    assign cnt_dec  = cmt_clr && !(iss_ok && (iss_rd == cmt_rd));

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (cmt_ok) begin
                val_q[cmt_rd] <= cmt_val;
            end
            if (iss_ok) begin
                tag_q[iss_rd] <= iss_tag;
            end
            if (flush_ok) begin
                busy_q <= '0;
            end else begin
                if (cmt_clr) begin
                    busy_q[cmt_rd] <= 1'b0;
                end
                if (iss_ok) begin
                    busy_q[iss_rd] <= 1'b1;
                end
            end
            if (flush_ok) begin
                cnt_q <= '0;
            end else if (cnt_inc && !cnt_dec) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (cnt_dec && !cnt_inc) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign busy_cnt = cnt_q;

    always_comb begin
        logic [REG_W-1:0] addr;
        logic [XLEN-1:0]  rv;
        logic             rb;
        logic [TAG_W-1:0] rt;
        rd_val  = '0;
        rd_busy = '0;
        rd_tag  = '0;
        addr    = '0;
        rv      = '0;
        rb      = 1'b0;
        rt      = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            addr = rd_addr[k*REG_W +: REG_W];
            rv   = val_q[addr];
            rb   = busy_q[addr];
            rt   = tag_q[addr];
`ifdef REGFILE_BYPASS_EN
            // Forward the committing value and the busy state it leaves behind.
            if (cmt_ok && (cmt_rd == addr)) begin
                rv = cmt_val;
                rb = rb && !cmt_clr && !flush_in;
            end
`endif
            if (addr == '0) begin
                rv = '0;
                rb = 1'b0;
                rt = '0;
            end
            rd_val[k*XLEN +: XLEN]   = rv;
            rd_busy[k]               = rb;
            rd_tag[k*TAG_W +: TAG_W] = rt;
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed bench for rename_regfile: rename/commit/flush/stall/reset scenarios,
// with the bypass expectations selected by REGFILE_BYPASS_EN.
module tb_rename_regfile;

    localparam int XLEN   = 32;
    localparam int TAG_W  = 4;
    localparam int NUM_RD = 2;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 6;

    logic                    clk_in;
    logic                    rst_in;
    logic                    rdy_in;
    logic                    flush_in;
    logic                    iss_en;
    logic [REG_W-1:0]        iss_rd;
    logic [TAG_W-1:0]        iss_tag;
    logic                    cmt_en;
    logic [REG_W-1:0]        cmt_rd;
    logic [XLEN-1:0]         cmt_val;
    logic [TAG_W-1:0]        cmt_tag;
    logic [NUM_RD*REG_W-1:0] rd_addr;
    logic [NUM_RD*XLEN-1:0]  rd_val;
    logic [NUM_RD-1:0]       rd_busy;
    logic [NUM_RD*TAG_W-1:0] rd_tag;
    logic [CNT_W-1:0]        busy_cnt;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] exp_q[$];

    rename_regfile dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .rdy_in   (rdy_in),
        .flush_in (flush_in),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .iss_tag  (iss_tag),
        .cmt_en   (cmt_en),
        .cmt_rd   (cmt_rd),
        .cmt_val  (cmt_val),
        .cmt_tag  (cmt_tag),
        .rd_addr  (rd_addr),
        .rd_val   (rd_val),
        .rd_busy  (rd_busy),
        .rd_tag   (rd_tag),
        .busy_cnt (busy_cnt)
    );

    // clock / reset
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // driver tasks
    task automatic idle();
        iss_en   = 1'b0;
        cmt_en   = 1'b0;
        flush_in = 1'b0;
        rdy_in   = 1'b1;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        idle();
        #1;
    endtask

    task automatic drive_iss(input logic [REG_W-1:0] rd, input logic [TAG_W-1:0] tag);
        iss_en  = 1'b1;
        iss_rd  = rd;
        iss_tag = tag;
    endtask

    task automatic drive_cmt(input logic [REG_W-1:0] rd, input logic [TAG_W-1:0] tag,
                             input logic [XLEN-1:0] v);
        cmt_en  = 1'b1;
        cmt_rd  = rd;
        cmt_tag = tag;
        cmt_val = v;
    endtask

    task automatic read(input logic [REG_W-1:0] a0, input logic [REG_W-1:0] a1);
        rd_addr = {a1, a0};
        #1;
    endtask

    // scoreboard
    task automatic check(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic check_port0(input string name, input logic [XLEN-1:0] v,
                               input logic b, input logic [TAG_W-1:0] t, input logic chk_tag);
        check({name, "_val"}, rd_val[XLEN-1:0], v);
        check({name, "_busy"}, XLEN'(rd_busy[0]), XLEN'(b));
        if (chk_tag) check({name, "_tag"}, XLEN'(rd_tag[TAG_W-1:0]), XLEN'(t));
    endtask

    initial begin
        rst_in   = 1'b0;
        iss_rd   = '0;
        iss_tag  = '0;
        cmt_rd   = '0;
        cmt_tag  = '0;
        cmt_val  = '0;
        rd_addr  = '0;
        idle();

        // Writes to r5 while in reset are ignored.
        drive_cmt(5'd5, 4'd0, 32'h55);
        drive_iss(5'd5, 4'd3);
        step();
        read(5'd5, 5'd0);
        check_port0("reset_r5", 32'h0, 1'b0, 4'd0, 1'b1);
        check("reset_cnt", XLEN'(busy_cnt), 32'd0);
        #3 rst_in = 1'b1;

        // Rename then matching commit.
        drive_iss(5'd3, 4'd7);
        step();
        read(5'd3, 5'd0);
        check_port0("iss_r3", 32'h0, 1'b1, 4'd7, 1'b1);
        check("iss_r3_cnt", XLEN'(busy_cnt), 32'd1);
        drive_cmt(5'd3, 4'd7, 32'hDEADBEEF);
        step();
        check_port0("cmt_r3", 32'hDEADBEEF, 1'b0, 4'd0, 1'b0);
        check("cmt_r3_cnt", XLEN'(busy_cnt), 32'd0);

        // Stale commit must not clear a newer rename.
        drive_iss(5'd3, 4'd2);
        step();
        drive_iss(5'd3, 4'd9);
        step();
        check("rerename_cnt", XLEN'(busy_cnt), 32'd1);
        drive_cmt(5'd3, 4'd2, 32'h11);
        step();
        check_port0("stale_r3", 32'h11, 1'b1, 4'd9, 1'b1);
        check("stale_cnt", XLEN'(busy_cnt), 32'd1);
        drive_cmt(5'd3, 4'd9, 32'h11);
        step();
        check("drain_r3_cnt", XLEN'(busy_cnt), 32'd0);

        // Same-cycle issue and commit on r4: issue wins busy/tag.
        drive_iss(5'd4, 4'd1);
        step();
        drive_iss(5'd4, 4'd5);
        drive_cmt(5'd4, 4'd1, 32'h22);
        step();
        read(5'd4, 5'd0);
        check_port0("isscmt_r4", 32'h22, 1'b1, 4'd5, 1'b1);
        check("isscmt_cnt", XLEN'(busy_cnt), 32'd1);

        // Flush with same-cycle issue (dropped) and commit (value kept).
        drive_iss(5'd1, 4'd1);
        step();
        drive_iss(5'd2, 4'd2);
        step();
        drive_iss(5'd6, 4'd3);
        step();
        check("pre_flush_cnt", XLEN'(busy_cnt), 32'd4);
        flush_in = 1'b1;
        drive_iss(5'd7, 4'd4);
        drive_cmt(5'd6, 4'd3, 32'h33);
        step();
        read(5'd6, 5'd7);
        check_port0("flush_r6", 32'h33, 1'b0, 4'd0, 1'b0);
        check("flush_r7_busy", XLEN'(rd_busy[1]), 32'd0);
        check("flush_cnt", XLEN'(busy_cnt), 32'd0);
        read(5'd4, 5'd1);
        check("flush_r4_busy", XLEN'(rd_busy[0]), 32'd0);
        check("flush_r1_busy", XLEN'(rd_busy[1]), 32'd0);

        // Stalled edge: nothing changes.
        rdy_in = 1'b0;
        drive_iss(5'd8, 4'd6);
        drive_cmt(5'd8, 4'd6, 32'h88);
        step();
        read(5'd8, 5'd0);
        check_port0("stall_r8", 32'h0, 1'b0, 4'd0, 1'b0);
        check("stall_cnt", XLEN'(busy_cnt), 32'd0);

        // Register 0 ignores issue and commit.
        drive_iss(5'd0, 4'd3);
        drive_cmt(5'd0, 4'd3, 32'h99);
        step();
        read(5'd0, 5'd0);
        check_port0("r0", 32'h0, 1'b0, 4'd0, 1'b1);
        check("r0_cnt", XLEN'(busy_cnt), 32'd0);

        // Sweep r1..r8 through port 1 against the expected queue.
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h33);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        for (int r = 1; r <= 8; r++) begin
            read(5'd0, REG_W'(r));
            check($sformatf("sweep_r%0d", r), rd_val[2*XLEN-1:XLEN], exp_q.pop_front());
        end

        // Commit read-in-flight: forwarded only with bypass.
        drive_iss(5'd9, 4'd6);
        step();
        drive_cmt(5'd9, 4'd6, 32'h44);
        read(5'd9, 5'd0);
`ifdef REGFILE_BYPASS_EN
        check_port0("byp_r9", 32'h44, 1'b0, 4'd0, 1'b0);
`else
        check_port0("byp_r9", 32'h0, 1'b1, 4'd6, 1'b1);
`endif
        step();
        check_port0("post_r9", 32'h44, 1'b0, 4'd0, 1'b0);
        check("post_r9_cnt", XLEN'(busy_cnt), 32'd0);

        // Asynchronous reset mid-run clears state without a clock edge.
        drive_iss(5'd10, 4'd2);
        step();
        check("pre_rst_cnt", XLEN'(busy_cnt), 32'd1);
        rst_in = 1'b0;
        read(5'd6, 5'd10);
        check("async_r6", rd_val[XLEN-1:0], 32'h0);
        check("async_r10_busy", XLEN'(rd_busy[1]), 32'd0);
        check("async_cnt", XLEN'(busy_cnt), 32'd0);
        rst_in = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
